memory_stream_reader: RTL and testbench
=======================================

Name: memory_stream_reader

Overview:
Read-side counterpart to the single-bit save cells. Holds an array of DEPTH words built from save-style storage, accepts writes through a save port, and streams a requested range of words out over a valid/ready interface. Downstream logic uses it to pull stored values back out of the memory block without addressing every word itself.

Parameters:
DATA_W, 8, width of each stored word
ADDR_W, 3, address width; DEPTH = 2^ADDR_W words

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
save  input  1  write strobe, sampled every cycle
save_addr  input  ADDR_W  write address
save_value  input  DATA_W  write data
rd_start  input  1  request a stream; honoured only when busy=0
rd_addr  input  ADDR_W  first address of stream
rd_len  input  ADDR_W+1  number of words, 1..DEPTH; 0 means no stream
out_ready  input  1  consumer accepts current word
out_valid  output  1  out_data holds a word
out_data  output  DATA_W  streamed word
out_last  output  1  current word is the final one of the stream
busy  output  1  stream in progress

Behaviour:
- Reset (rst=1 at an edge): all memory words := 0; out_valid, out_last, busy := 0; out_data := 0; state := IDLE. Reset overrides save and rd_start on the same edge. Reset mid-stream abandons the stream with no further beats.
- Save: when save=1 at an edge, mem[save_addr] := save_value. Accepted in every state, including during a stream.
- FSM states: IDLE and STREAM.
- IDLE: busy=0, out_valid=0. If rd_start=1 and rd_len!=0 at edge T, then at T+1: state=STREAM, busy=1, out_valid=1, out_data=word[rd_addr], out_last=(rd_len==1). Internal pointer := rd_addr+1 and remaining := rd_len-1. If rd_start=1 with rd_len=0, the request is ignored.
- Fetch bypass: a word is fetched combinationally at the edge that loads it. If save=1 to the same address on that edge, the fetched value is save_value (write-first).
- STREAM: out_valid stays at 1. out_data and out_last hold their values while out_ready=0.
  - On a handshake (out_valid & out_ready) at edge t with out_last=0: at t+1 the next word is presented, with no bubble, and the pointer advances.
  - On a handshake with out_last=1: at t+1 out_valid=0, out_last=0, busy=0, state=IDLE.
- Address arithmetic: the pointer increments modulo DEPTH, so a stream wraps from DEPTH-1 to 0. rd_len=DEPTH reads every word exactly once.
- Writes during a stream: words not yet fetched reflect the new value. A word already presented is not updated.
- rd_start while busy=1 is ignored. This includes the cycle of the final handshake. A new request is accepted no earlier than the first IDLE cycle.
- out_data retains its last value after the stream ends. Consumers qualify it only with out_valid.
- Throughput: 1 word/cycle with out_ready held high. Latency from rd_start to first out_valid is 1 cycle.

Test Plan:
- Reset then a stream: rst, then rd_start addr=0 len=8 with out_ready=1 -> 8 beats of 0x00 on consecutive cycles; out_last only on beat 8; busy drops the cycle after.
- Save then read with wrap: save mem[6]=0xA5, mem[7]=0x3C, mem[0]=0x11; rd_start addr=6 len=3, out_ready=1 -> beats 0xA5, 0x3C, 0x11 with out_last on 0x11; first out_valid 1 cycle after rd_start.
- Backpressure: stream addr=2 len=2; hold out_ready=0 for 3 cycles after out_valid -> out_data is stable at mem[2] and out_last=0 throughout; raise out_ready -> mem[3] next cycle with out_last=1.
- Write-first and mid-stream write:
  - save addr=4 value=0x77 on the same edge as rd_start addr=4 len=1 -> beat 0x77.
  - During a len=4 stream from 0, save mem[3]=0xEE while beat 1 is held -> beat 4 = 0xEE.
- Ignored requests:
  - rd_start with len=0 -> busy stays 0 and no beats.
  - rd_start addr=5 during an active stream -> the stream continues unchanged and no second stream starts.
- Reset mid-stream: rst asserted after beat 2 of a len=6 stream -> next cycle out_valid=0, busy=0, out_last=0; a subsequent read returns 0x00 for all words.

Source files
------------

// File: rtl/memory_stream_reader.sv
// memory_stream_reader: save-port word memory streamed out over valid/ready
module memory_stream_reader #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              save,
   input  logic [ADDR_W-1:0] save_addr,
   input  logic [DATA_W-1:0] save_value,
   input  logic              rd_start,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [ADDR_W:0]   rd_len,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
);
   localparam int DEPTH = 1 << ADDR_W;
   typedef enum logic {IDLE, STREAM} state_t;
   state_t state, state_n;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] ptr, ptr_n, fa;
   logic [ADDR_W:0]   rem, rem_n;
   logic [DATA_W-1:0] fetched, data_n;
   logic              load;
   // rem counts words still to present after the current one
   always_comb begin
      fa      = state == IDLE ? rd_addr : ptr;
      fetched = save && save_addr == fa ? save_value : mem[fa];
      load    = state == IDLE ? rd_start && rd_len != '0 : out_ready && rem != '0;
      state_n = state == IDLE ? (load ? STREAM : IDLE) : (out_ready && rem == '0 ? IDLE : STREAM);
      ptr_n   = load ? fa + 1'b1 : ptr;
      rem_n   = !load ? rem : state == IDLE ? rd_len - 1'b1 : rem - 1'b1;
      data_n  = load ? fetched : out_data;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         state    <= IDLE;
         ptr      <= '0;
         rem      <= '0;
         out_data <= '0;
      end else begin
         if (save) mem[save_addr] <= save_value;
         state    <= state_n;
         ptr      <= ptr_n;
         rem      <= rem_n;
         out_data <= data_n;
      end
   end
   assign busy      = state == STREAM;
   assign out_valid = busy;
   assign out_last  = busy && rem == '0;
endmodule

// File: tb/tb_memory_stream_reader.sv
// tb_memory_stream_reader: directed checks of streaming, wrap, backpressure, bypass and reset
module tb_memory_stream_reader;
   logic       clk = 0, rst = 1, save = 0, rd_start = 0, out_ready = 0;
   logic [2:0] save_addr = 0, rd_addr = 0;
   logic [7:0] save_value = 0;
   logic [3:0] rd_len = 0;
   logic       out_valid, out_last, busy;
   logic [7:0] out_data;
   int         n_checks = 0, n_fail = 0;

   memory_stream_reader #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk(clk), .rst(rst), .save(save), .save_addr(save_addr), .save_value(save_value),
      .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " valid"}, 32'(out_valid), 32'd0);
      chk({tag, " last"}, 32'(out_last), 32'd0);
   endtask

   // expects n beats v[0..n-1] with out_ready held high, then idle
   task automatic expect_beats(input string tag, input int n, input logic [7:0] v [8]);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s beat%0d valid", tag, i), 32'(out_valid), 32'd1);
         chk($sformatf("%s beat%0d data", tag, i), 32'(out_data), 32'(v[i]));
         chk($sformatf("%s beat%0d last", tag, i), 32'(out_last), 32'(i == n - 1));
         step();
      end
      idle_chk({tag, " end"});
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      save = 1; save_addr = a; save_value = d;
      step();
      save = 0;
   endtask

   initial begin
      @(negedge clk);
      step();
      rst = 0;
      idle_chk("reset");
      chk("reset data", 32'(out_data), 32'd0);

      out_ready = 1; rd_start = 1; rd_addr = 0; rd_len = 8;
      step();
      rd_start = 0;
      expect_beats("zeros", 8, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

      wr(6, 8'hA5); wr(7, 8'h3C); wr(0, 8'h11);
      rd_start = 1; rd_addr = 6; rd_len = 3;
      step();
      rd_start = 0;
      expect_beats("wrap", 3, '{8'hA5, 8'h3C, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

      wr(2, 8'h22); wr(3, 8'h33);
      out_ready = 0; rd_start = 1; rd_addr = 2; rd_len = 2;
      step();
      rd_start = 0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp hold%0d valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("bp hold%0d data", i), 32'(out_data), 32'h22);
         chk($sformatf("bp hold%0d last", i), 32'(out_last), 32'd0);
         step();
      end
      out_ready = 1;
      expect_beats("bp release", 2, '{8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

      save = 1; save_addr = 4; save_value = 8'h77; rd_start = 1; rd_addr = 4; rd_len = 1;
      step();
      save = 0; rd_start = 0;
      expect_beats("bypass", 1, '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

      out_ready = 0; rd_start = 1; rd_addr = 0; rd_len = 4;
      step();
      rd_start = 0;
      wr(3, 8'hEE);
      chk("midwr held data", 32'(out_data), 32'h11);
      out_ready = 1;
      expect_beats("midwr", 4, '{8'h11, 8'h00, 8'h22, 8'hEE, 8'h00, 8'h00, 8'h00, 8'h00});

      rd_start = 1; rd_addr = 0; rd_len = 0;
      step();
      idle_chk("len0 a");
      step();
      rd_start = 0;
      idle_chk("len0 b");

      rd_start = 1; rd_addr = 0; rd_len = 3;
      step();
      rd_addr = 5; rd_len = 2;
      expect_beats("busy ign", 3, '{8'h11, 8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      rd_start = 0;
      step();
      idle_chk("busy ign after");

      rd_start = 1; rd_addr = 2; rd_len = 6;
      step();
      rd_start = 0;
      chk("rstmid beat0", 32'(out_data), 32'h22);
      step();
      chk("rstmid beat1", 32'(out_data), 32'hEE);
      rst = 1;
      step();
      rst = 0;
      idle_chk("rstmid");
      chk("rstmid data", 32'(out_data), 32'd0);
      rd_start = 1; rd_addr = 5; rd_len = 8;
      step();
      rd_start = 0;
      expect_beats("post rst", 8, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
